aes_fifo_host_driver: RTL and testbench
=======================================

Name: aes_fifo_host_driver

Overview:
- Host-side counterpart of the 8-bit AES FIFO consumer.
- Buffers up to DEPTH {key, data} byte pairs loaded over a simple config port.
- On start, writes them as 32-bit words into the AES input FIFO, tagging the final word with 16'h1111.
- Drains the same number of result words from the AES output FIFO into a result buffer and signals done.

Parameters:
- DATA_WIDTH, 32, FIFO word width (min 32).
- DEPTH, 16, number of entries in the command and result buffers (power of 2).
- ADDR_W, 4, log2(DEPTH).
- LAST_TAG, 16'h1111, tag value in word [31:16] marking the final input word.
- TIMEOUT_CYCLES, 1024, stall limit; used only with the optional feature.

Ports:
- clock  in  1  system clock.
- reset_n  in  1  synchronous reset, active-high (the port name is kept for codebase consistency).
- cfg_wr  in  1  write one command buffer entry.
- cfg_addr  in  ADDR_W  command buffer index.
- cfg_key  in  8  key byte for the entry.
- cfg_data  in  8  data byte for the entry.
- start  in  1  begin a run.
- start_len  in  ADDR_W+1  number of entries to send, 0..DEPTH; sampled with start.
- busy  out  1  run in progress.
- done  out  1  one-cycle pulse at end of run.
- err_timeout  out  1  sticky stall error.
- res_cnt  out  ADDR_W+1  results captured in the last run.
- res_addr  in  ADDR_W  result buffer read index.
- res_data  out  8  result byte at res_addr (combinational read).
- in_full  in  1  AES input FIFO full.
- in_wr  out  1  push to AES input FIFO.
- in_dout  out  DATA_WIDTH  word pushed.
- out_empty  in  1  AES output FIFO empty.
- out_rd  out  1  pop from AES output FIFO.
- out_din  in  DATA_WIDTH  head word of AES output FIFO (first-word-fall-through).

Behaviour:
- One clock; reset is synchronous and active-high.
- On reset: state=IDLE, busy=0, done=0, err_timeout=0, res_cnt=0, tx_idx=0, rx_idx=0, len=0. in_wr=0 and out_rd=0, since both decode from state.
- Buffer contents are not reset.
- States: IDLE, SEND, DRAIN, FIN.
- IDLE:
  - cfg_wr writes cmd[cfg_addr] = {cfg_key, cfg_data}.
  - start with start_len>0: latch len (clamped to DEPTH), clear tx_idx, rx_idx, res_cnt and err_timeout, go to SEND.
  - start with start_len==0: go to FIN; no FIFO traffic.
- cfg_wr and start outside IDLE are ignored.
- busy=1 in SEND and DRAIN.
- SEND:
  - in_wr = ~in_full (combinational); the push occurs in any cycle where in_wr=1.
  - in_dout[31:16] = (tx_idx==len-1) ? LAST_TAG : 16'h0000.
  - in_dout[15:8] = key of cmd[tx_idx]; in_dout[7:0] = data of cmd[tx_idx]; bits above 31 are zero.
  - Each push increments tx_idx. The push with tx_idx==len-1 moves to DRAIN on the next cycle.
  - in_full high stalls with in_wr=0 and tx_idx held; no word is ever dropped or duplicated.
- DRAIN:
  - out_rd = ~out_empty.
  - On each pop: res[rx_idx] = out_din[7:0], rx_idx++, res_cnt++. Upper bits of out_din are ignored.
  - The pop that makes rx_idx==len moves to FIN. No extra pops occur, even if out_empty stays low.
- FIN: done=1 for exactly one cycle, then IDLE. res_cnt and the result buffer hold until the next start.
- Latency: minimum len cycles in SEND plus len cycles in DRAIN, plus 1 FIN cycle after start.
- Reset mid-run: returns to IDLE at once; in_wr/out_rd deassert in the next cycle. Partial results remain in the buffer but res_cnt=0.
- Index width ADDR_W+1 so len==DEPTH is representable; tx_idx and rx_idx never wrap within a run.

Optional Feature:
- Macro: AES_HOST_TIMEOUT_EN.
- Defined:
  - A stall counter clears on every push/pop and on entry to SEND/DRAIN.
  - It increments each SEND/DRAIN cycle with no handshake.
  - On reaching TIMEOUT_CYCLES: err_timeout=1 (sticky until next start), go to FIN. done pulses; res_cnt holds the partial count.
- Not defined: no counter; waits indefinitely; err_timeout tied to 0.

Test Plan:
- Load cmd[0..2] = {8'h2B,8'h32}, {8'h7E,8'h43}, {8'h15,8'hF6}; start, len=3; FIFOs never full/empty -> in_dout sequence 32'h00002B32, 32'h00007E43, 32'h111115F6 on 3 consecutive cycles. Then 3 pops of out_din = 32'hA5, 32'h3C, 32'h01 -> res[0..2] = A5, 3C, 01; res_cnt=3; done pulses once.
- in_full high for 5 cycles after the first push, len=3 -> in_wr low while full; exactly 3 words written, no repeat of word 1.
- out_empty toggling every other cycle, len=4 -> exactly 4 pops; out_rd never asserted while out_empty=1; out_empty forced low afterwards causes no 5th pop.
- start with start_len=0 -> done pulse 1 cycle later, in_wr/out_rd never asserted, res_cnt=0. start and cfg_wr while busy -> no effect.
- Reset asserted during DRAIN after 2 of 4 pops -> next cycle state IDLE, busy=0, out_rd=0, res_cnt=0; a new run of len=1 completes normally.
- With AES_HOST_TIMEOUT_EN, TIMEOUT_CYCLES=8, out_empty held high in DRAIN -> after 8 stall cycles err_timeout=1 and done pulses; next start clears err_timeout.

Source files
------------

// File: rtl/aes_fifo_host_driver.sv
// ---------------------------------------------------------------------------
// aes_fifo_host_driver
//
// Host-side driver for the 8-bit AES FIFO consumer. A small command buffer is
// loaded with {key, data} byte pairs over the cfg_* port. A start pulse
// streams the first start_len entries into the AES input FIFO as 32-bit
// words (the final word tagged with LAST_TAG in bits [31:16]). The driver
// then pops the same number of result words from the AES output FIFO and
// keeps their low bytes in a result buffer. done pulses for one cycle at the
// end of the run.
//
// Ports:
//   clock        system clock
//   reset_n      synchronous reset, active-HIGH despite the name
//   cfg_wr/cfg_addr/cfg_key/cfg_data   command buffer write (IDLE only)
//   start/start_len   begin a run of start_len entries (0..DEPTH, clamped)
//   busy         run in progress (SEND or DRAIN)
//   done         one-cycle pulse at end of run
//   err_timeout  sticky stall error (optional feature, else 0)
//   res_cnt      results captured in the last run
//   res_addr/res_data   combinational result buffer read
//   in_full/in_wr/in_dout      AES input FIFO write side
//   out_empty/out_rd/out_din   AES output FIFO read side (first-word-fall-through)
//
// Build option:
//   AES_HOST_TIMEOUT_EN  when defined, a run that sees TIMEOUT_CYCLES
//                        consecutive cycles without a push/pop is aborted
//                        with err_timeout set.
// ---------------------------------------------------------------------------
module aes_fifo_host_driver #(
    parameter int          DATA_WIDTH     = 32,
    parameter int          DEPTH          = 16,
    parameter int          ADDR_W         = 4,
    parameter logic [15:0] LAST_TAG       = 16'h1111,
    parameter int          TIMEOUT_CYCLES = 1024
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  cfg_wr,
    input  logic [ADDR_W-1:0]     cfg_addr,
    input  logic [7:0]            cfg_key,
    input  logic [7:0]            cfg_data,
    input  logic                  start,
    input  logic [ADDR_W:0]       start_len,
    output logic                  busy,
    output logic                  done,
    output logic                  err_timeout,
    output logic [ADDR_W:0]       res_cnt,
    input  logic [ADDR_W-1:0]     res_addr,
    output logic [7:0]            res_data,
    input  logic                  in_full,
    output logic                  in_wr,
    output logic [DATA_WIDTH-1:0] in_dout,
    input  logic                  out_empty,
    output logic                  out_rd,
    input  logic [DATA_WIDTH-1:0] out_din
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        DRAIN = 2'd2,
        FIN   = 2'd3
    } state_t;

    localparam logic [ADDR_W:0] DEPTH_LEN = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] ONE       = (ADDR_W+1)'(1);

    state_t          state_reg;
    logic [ADDR_W:0] len_reg;
    logic [ADDR_W:0] tx_idx_reg;
    logic [ADDR_W:0] rx_idx_reg;
    logic [ADDR_W:0] res_cnt_reg;
    logic            busy_reg;
    logic            done_reg;
    logic            err_reg;

    logic [15:0]     cmd_mem [DEPTH];
    logic [7:0]      res_mem [DEPTH];

    logic [ADDR_W:0] start_len_clamped;
    logic            last_tx;
    logic            last_rx;
    logic [15:0]     cmd_word;
    logic            timeout_hit;

    // Upper bits of the result word carry nothing for an 8-bit consumer.
    logic            unused_din_bits;
    assign unused_din_bits = ^out_din[DATA_WIDTH-1:8];

    assign start_len_clamped = (start_len > DEPTH_LEN) ? DEPTH_LEN : start_len;

    // FIFO strobes decode straight from the state register so a stall on
    // in_full/out_empty takes effect in the same cycle.
    assign in_wr  = (state_reg == SEND)  && !in_full;
    assign out_rd = (state_reg == DRAIN) && !out_empty;

    // len_reg >= 1 whenever these are consulted (SEND/DRAIN only).
    assign last_tx = (tx_idx_reg == len_reg - ONE);
    assign last_rx = (rx_idx_reg == len_reg - ONE);

    assign cmd_word = cmd_mem[tx_idx_reg[ADDR_W-1:0]];

    always_comb begin
        in_dout        = '0;
        in_dout[31:16] = last_tx ? LAST_TAG : 16'h0000;
        in_dout[15:0]  = cmd_word;
    end

    assign res_data    = res_mem[res_addr];
    assign busy        = busy_reg;
    assign done        = done_reg;
    assign err_timeout = err_reg;
    assign res_cnt     = res_cnt_reg;

`ifdef AES_HOST_TIMEOUT_EN
    localparam int                 STALL_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [STALL_W-1:0] STALL_LIMIT = STALL_W'(TIMEOUT_CYCLES - 1);

    logic [STALL_W-1:0] stall_reg;
    logic               stalled;

    // A stall is any SEND/DRAIN cycle without a handshake. The counter is
    // zero in IDLE/FIN, so it always starts from zero on entry to SEND, and
    // the final push clears it right before DRAIN.
    assign stalled     = ((state_reg == SEND) && in_full) ||
                         ((state_reg == DRAIN) && out_empty);
    assign timeout_hit = stalled && (stall_reg == STALL_LIMIT);

    always_ff @(posedge clock) begin
        if (reset_n || !stalled) begin
            stall_reg <= '0;
        end else begin
            stall_reg <= stall_reg + 1'b1;
        end
    end
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
    assign timeout_hit = 1'b0;
`endif

    // Command buffer: written only while idle, contents survive reset.
    always_ff @(posedge clock) begin
        if ((state_reg == IDLE) && cfg_wr) begin
            cmd_mem[cfg_addr] <= {cfg_key, cfg_data};
        end
    end

    // Result buffer: one byte per pop, contents survive reset.
    always_ff @(posedge clock) begin
        if (out_rd) begin
            res_mem[rx_idx_reg[ADDR_W-1:0]] <= out_din[7:0];
        end
    end

    always_ff @(posedge clock) begin
        if (reset_n) begin
            state_reg   <= IDLE;
            len_reg     <= '0;
            tx_idx_reg  <= '0;
            rx_idx_reg  <= '0;
            res_cnt_reg <= '0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            err_reg     <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    done_reg <= 1'b0;
                    if (start) begin
                        tx_idx_reg  <= '0;
                        rx_idx_reg  <= '0;
                        res_cnt_reg <= '0;
                        err_reg     <= 1'b0;
                        if (start_len == '0) begin
                            // Empty run: report completion without FIFO traffic.
                            len_reg   <= '0;
                            state_reg <= FIN;
                            done_reg  <= 1'b1;
                        end else begin
                            len_reg   <= start_len_clamped;
                            state_reg <= SEND;
                            busy_reg  <= 1'b1;
                        end
                    end
                end

                SEND: begin
                    if (timeout_hit) begin
                        err_reg   <= 1'b1;
                        state_reg <= FIN;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                    end else if (in_wr) begin
                        tx_idx_reg <= tx_idx_reg + ONE;
                        if (last_tx) begin
                            state_reg <= DRAIN;
                        end
                    end
                end

                DRAIN: begin
                    if (timeout_hit) begin
                        err_reg   <= 1'b1;
                        state_reg <= FIN;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                    end else if (out_rd) begin
                        rx_idx_reg  <= rx_idx_reg + ONE;
                        res_cnt_reg <= res_cnt_reg + ONE;
                        if (last_rx) begin
                            state_reg <= FIN;
                            busy_reg  <= 1'b0;
                            done_reg  <= 1'b1;
                        end
                    end
                end

                FIN: begin
                    state_reg <= IDLE;
                    done_reg  <= 1'b0;
                end

                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_fifo_host_driver.sv
// ---------------------------------------------------------------------------
// tb_aes_fifo_host_driver
//
// Self-checking bench for aes_fifo_host_driver. Each run is predicted by a
// transaction-level model: a queue of expected input-FIFO words built from
// the command buffer image, counts of words sent / results popped, and the
// protocol rules (push whenever not full until len words are out, drain
// starts the cycle after the last push, done the cycle after the last pop).
// ---------------------------------------------------------------------------
module tb_aes_fifo_host_driver;

    localparam int DW    = 32;
    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int TMO   = 8;

`ifdef AES_HOST_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          reset_n = 1'b1;
    logic          cfg_wr = 1'b0;
    logic [AW-1:0] cfg_addr = '0;
    logic [7:0]    cfg_key = '0;
    logic [7:0]    cfg_data = '0;
    logic          start = 1'b0;
    logic [AW:0]   start_len = '0;
    logic          busy;
    logic          done;
    logic          err_timeout;
    logic [AW:0]   res_cnt;
    logic [AW-1:0] res_addr = '0;
    logic [7:0]    res_data;
    logic          in_full = 1'b0;
    logic          in_wr;
    logic [DW-1:0] in_dout;
    logic          out_empty = 1'b0;
    logic          out_rd;
    logic [DW-1:0] out_din = '0;

    always #5 clock = ~clock;

    aes_fifo_host_driver #(
        .DATA_WIDTH     (DW),
        .DEPTH          (DEPTH),
        .ADDR_W         (AW),
        .LAST_TAG       (16'h1111),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .cfg_wr      (cfg_wr),
        .cfg_addr    (cfg_addr),
        .cfg_key     (cfg_key),
        .cfg_data    (cfg_data),
        .start       (start),
        .start_len   (start_len),
        .busy        (busy),
        .done        (done),
        .err_timeout (err_timeout),
        .res_cnt     (res_cnt),
        .res_addr    (res_addr),
        .res_data    (res_data),
        .in_full     (in_full),
        .in_wr       (in_wr),
        .in_dout     (in_dout),
        .out_empty   (out_empty),
        .out_rd      (out_rd),
        .out_din     (out_din)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    logic [15:0] cmd_model [DEPTH];
    logic [7:0]  res_model [DEPTH];
    logic [31:0] push_log [$];
    logic [31:0] din_q [$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called and returns at posedge+1.
    task automatic cfg_write(input int addr, input logic [7:0] k, input logic [7:0] d);
        cfg_wr   = 1'b1;
        cfg_addr = AW'(addr);
        cfg_key  = k;
        cfg_data = d;
        cmd_model[addr] = {k, d};
        @(posedge clock); #1;
        cfg_wr = 1'b0;
    endtask

    // pattern: 0 random stalls, 1 in_full high 5 cycles after first push,
    //          2 out_empty toggling, 3 output FIFO never delivers.
    task automatic run_case(input int len_req, input int pattern, input int full_pct,
                            input int empty_pct, input bit use_din);
        int n, sent, popped, full_hold, stall, cyc;
        bit drain_live, fin_now, timed_out, done_seen, exp_wr, exp_rd;
        logic [31:0] exp_q [$];

        n = (len_req > DEPTH) ? DEPTH : len_req;
        for (int i = 0; i < n; i++)
            exp_q.push_back({(i == n - 1) ? 16'h1111 : 16'h0000, cmd_model[i]});
        push_log.delete();

        start     = 1'b1;
        start_len = (AW+1)'(len_req);
        @(posedge clock); #1;
        start = 1'b0;

        sent = 0; popped = 0; full_hold = 0; stall = 0; cyc = 0;
        drain_live = 1'b0; fin_now = (n == 0); timed_out = 1'b0; done_seen = 1'b0;

        while (!done_seen && cyc < 3000) begin
            if (pattern == 1) begin
                in_full = 1'b0;
                if (sent >= 1) begin
                    in_full = (full_hold < 5);
                    full_hold++;
                end
            end else if (pattern == 3) begin
                in_full = 1'b0;
            end else begin
                in_full = ($urandom_range(99) < full_pct);
            end
            if (pattern == 2)      out_empty = cyc[0];
            else if (pattern == 3) out_empty = 1'b1;
            else                   out_empty = ($urandom_range(99) < empty_pct);
            out_din   = (use_din && popped < din_q.size()) ? din_q[popped] : $urandom;
            // Commands while running must be ignored.
            start     = ($urandom_range(3) == 0);
            start_len = (AW+1)'($urandom);
            cfg_wr    = ($urandom_range(3) == 0);
            cfg_addr  = AW'($urandom);
            cfg_key   = 8'($urandom);
            cfg_data  = 8'($urandom);

            @(negedge clock);
            exp_wr = !fin_now && (sent < n) && !in_full;
            exp_rd = !fin_now && drain_live && (popped < n) && !out_empty;
            check("in_wr", in_wr, exp_wr);
            check("out_rd", out_rd, exp_rd);
            check("busy", busy, !fin_now);
            check("done", done, fin_now);
            check("err_timeout", err_timeout, timed_out);
            if (exp_wr) begin
                check("in_dout", in_dout, exp_q[sent]);
                push_log.push_back(in_dout);
                sent++;
            end
            if (exp_rd) begin
                res_model[popped] = out_din[7:0];
                popped++;
            end
            if (fin_now) begin
                done_seen = 1'b1;
            end else begin
                if (TMO_EN) begin
                    if (exp_wr || exp_rd) stall = 0;
                    else                  stall++;
                    if (stall == TMO) timed_out = 1'b1;
                end
                if (sent == n) drain_live = 1'b1;
                fin_now = (popped == n) || timed_out;
            end
            cyc++;
            @(posedge clock); #1;
        end

        start = 1'b0; cfg_wr = 1'b0; in_full = 1'b0; out_empty = 1'b0;
        check("run_reached_end", done_seen, 1'b1);

        // Idle with both FIFOs ready: no stray traffic, done already gone.
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            check("idle_done", done, 1'b0);
            check("idle_in_wr", in_wr, 1'b0);
            check("idle_out_rd", out_rd, 1'b0);
            check("idle_busy", busy, 1'b0);
            @(posedge clock); #1;
        end
        check("res_cnt", res_cnt, popped);
        check("err_hold", err_timeout, timed_out);
        for (int i = 0; i < popped; i++) begin
            res_addr = AW'(i);
            #1;
            check("res_data", res_data, res_model[i]);
        end
        $display("[TB] run len_req=%0d len=%0d pattern=%0d sent=%0d popped=%0d timeout=%0d",
                 len_req, n, pattern, sent, popped, timed_out);
        @(posedge clock); #1;
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int pops;
        logic [7:0] rst_res [2];

        // Reset state
        reset_n = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        @(negedge clock);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_err", err_timeout, 1'b0);
        check("rst_res_cnt", res_cnt, 0);
        check("rst_in_wr", in_wr, 1'b0);
        check("rst_out_rd", out_rd, 1'b0);
        @(posedge clock); #1;
        reset_n = 1'b0;
        @(posedge clock); #1;

        for (int i = 0; i < DEPTH; i++)
            cfg_write(i, 8'($urandom), 8'($urandom));

        // Directed: three known entries, FIFOs always ready
        cfg_write(0, 8'h2B, 8'h32);
        cfg_write(1, 8'h7E, 8'h43);
        cfg_write(2, 8'h15, 8'hF6);
        din_q.delete();
        din_q.push_back(32'h000000A5);
        din_q.push_back(32'h0000003C);
        din_q.push_back(32'h00000001);
        run_case(3, 0, 0, 0, 1'b1);
        check("tp1_nwords", push_log.size(), 3);
        if (push_log.size() == 3) begin
            check("tp1_w0", push_log[0], 32'h00002B32);
            check("tp1_w1", push_log[1], 32'h00007E43);
            check("tp1_w2", push_log[2], 32'h111115F6);
        end
        res_addr = 0; #1; check("tp1_r0", res_data, 8'hA5);
        res_addr = 1; #1; check("tp1_r1", res_data, 8'h3C);
        res_addr = 2; #1; check("tp1_r2", res_data, 8'h01);
        check("tp1_res_cnt", res_cnt, 3);
        @(posedge clock); #1;

        // Input FIFO full for 5 cycles after the first push
        run_case(3, 1, 0, 0, 1'b0);
        check("full_nwords", push_log.size(), 3);

        // Output FIFO empty every other cycle
        run_case(4, 2, 0, 0, 1'b0);

        // Zero-length run after a non-empty one
        run_case(0, 0, 0, 0, 1'b0);

        // Full-depth and over-length requests
        run_case(DEPTH, 0, 20, 20, 1'b0);
        run_case(DEPTH + 5, 0, 20, 20, 1'b0);

        // Reset during DRAIN after 2 of 4 pops
        in_full = 1'b0; out_empty = 1'b0;
        start = 1'b1; start_len = 5'd4;
        @(posedge clock); #1;
        start = 1'b0;
        pops = 0;
        for (int c = 0; c < 50 && pops < 2; c++) begin
            out_din = $urandom;
            @(negedge clock);
            if (out_rd) begin
                rst_res[pops] = out_din[7:0];
                pops++;
            end
            @(posedge clock); #1;
        end
        check("rst_mid_pops", pops, 2);
        out_empty = 1'b1;
        reset_n   = 1'b1;
        @(posedge clock); #1;
        reset_n   = 1'b0;
        out_empty = 1'b0;
        @(negedge clock);
        check("rst_mid_busy", busy, 1'b0);
        check("rst_mid_out_rd", out_rd, 1'b0);
        check("rst_mid_res_cnt", res_cnt, 0);
        check("rst_mid_done", done, 1'b0);
        res_addr = 0; #1; check("rst_mid_r0", res_data, rst_res[0]);
        res_addr = 1; #1; check("rst_mid_r1", res_data, rst_res[1]);
        @(posedge clock); #1;
        run_case(1, 0, 0, 0, 1'b0);

`ifdef AES_HOST_TIMEOUT_EN
        // Output FIFO never delivers: run must abort after TMO stalls
        run_case(2, 3, 0, 0, 1'b0);
        check("tmo_err", err_timeout, 1'b1);
        run_case(2, 0, 0, 0, 1'b0);
        check("tmo_cleared", err_timeout, 1'b0);
`endif

        // Randomised runs with partial buffer reloads
        for (int r = 0; r < 25; r++) begin
            int nload;
            nload = $urandom_range(4);
            for (int j = 0; j < nload; j++)
                cfg_write($urandom_range(DEPTH - 1), 8'($urandom), 8'($urandom));
            run_case($urandom_range(20), 0, $urandom_range(60), $urandom_range(60), 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
